// File: rtl/id_ctrl_pkg.sv
// Shared definitions for the ID-stage control pipeline: opcodes, ALU-op and
// reg_dst codes, the registered control bundle, the opcode decoder and the
// load-use hazard FSM state type.
package id_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_SLT   = 3'd4;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       branch;
        logic       branch_ne;
        logic       jump;
        logic       link;
        logic [1:0] reg_dst;
        logic [2:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    typedef enum logic {
        RUN     = 1'b0,
        LU_WAIT = 1'b1
    } hz_state_t;

    // Control bundle for one opcode; anything not listed becomes a bubble.
    function automatic ctrl_t decode(input logic [5:0] opcode);
        ctrl_t c;
        c = CTRL_BUBBLE;
        case (opcode)
            OP_RTYPE: begin
                c.reg_write = 1'b1;
                c.reg_dst   = DST_RD;
                c.alu_op    = ALU_FUNCT;
            end
            OP_ADDI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_op    = ALU_ADD;
            end
            OP_SLTI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_op    = ALU_SLT;
            end
            OP_ORI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_op    = ALU_OR;
            end
            OP_LW: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.mem_read   = 1'b1;
                c.alu_src    = 1'b1;
                c.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_op    = ALU_ADD;
            end
            OP_BEQ: begin
                c.branch = 1'b1;
                c.alu_op = ALU_SUB;
            end
            OP_BNE: begin
                c.branch_ne = 1'b1;
                c.alu_op    = ALU_SUB;
            end
            OP_J: begin
                c.jump = 1'b1;
            end
            OP_JAL: begin
                c.reg_write = 1'b1;
                c.jump      = 1'b1;
                c.link      = 1'b1;
                c.reg_dst   = DST_RA;
            end
            default: c = CTRL_BUBBLE;
        endcase
        return c;
    endfunction

    // True for every opcode the decoder understands.
    function automatic logic is_known(input logic [5:0] opcode);
        case (opcode)
            OP_RTYPE, OP_ADDI, OP_SLTI, OP_ORI, OP_LW, OP_SW,
            OP_BEQ, OP_BNE, OP_J, OP_JAL: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    // Opcodes that read rt as a source operand (not just as a destination).
    function automatic logic uses_rt(input logic [5:0] opcode);
        case (opcode)
            OP_RTYPE, OP_SW, OP_BEQ, OP_BNE: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_hazard_fsm.sv
// Load-use hazard detection: compares the load in EX against the sources of
// the instruction in ID and inserts LU_STALLS bubbles, freezing PC and IF/ID.
module id_hazard_fsm
    import id_ctrl_pkg::*;
#(
    parameter int LU_STALLS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mem_read_ex,
    input  logic [4:0] dest_ex,
    input  logic       valid_id,
    input  logic       kill_id,
    input  logic [4:0] rs_id,
    input  logic [4:0] rt_id,
    input  logic       uses_rt_id,
    input  logic       flush,
    input  logic       stall_ext,
    output logic       hazard_bubble,
    output logic       hazard_stall
);

    localparam int CNT_W = (LU_STALLS > 1) ? $clog2(LU_STALLS + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'((LU_STALLS > 1) ? (LU_STALLS - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             detect;

    // Load in EX whose non-zero destination is read by the live ID instruction.
    always_comb begin
        detect = (LU_STALLS > 0) && mem_read_ex && (dest_ex != 5'd0) &&
                 valid_id && !kill_id &&
                 ((dest_ex == rs_id) || ((dest_ex == rt_id) && uses_rt_id));
    end

    // State and remaining-bubble counter; reset drops straight back to RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: flush aborts, external stall freezes, otherwise count bubbles.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hazard_bubble = ((state_q == RUN) && detect) || (state_q == LU_WAIT);
        hazard_stall  = hazard_bubble && !flush;
        if (flush) begin
            state_d = RUN;
            cnt_d   = '0;
        end else if (stall_ext) begin
            state_d = state_q;
            cnt_d   = cnt_q;
        end else begin
            case (state_q)
                RUN: begin
                    if (detect && (LU_STALLS > 1)) begin
                        state_d = LU_WAIT;
                        cnt_d   = CNT_RELOAD;
                    end
                end
                LU_WAIT: begin
                    if (cnt_q == CNT_ONE) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/id_ctrl_pipe.sv
// ID-stage control for the 5-stage MIPS32 core: decodes the IF/ID opcode and
// registers the control bundle into ID/EX, inserting bubbles for flushes,
// load-use hazards, killed or invalid slots, and flagging illegal opcodes.
module id_ctrl_pipe
    import id_ctrl_pkg::*;
#(
    parameter int         ALUOP_W   = 3,
    parameter int         LU_STALLS = 1,
    parameter logic [5:0] NOP_OP    = 6'b100000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        instr_id,
    input  logic               valid_id,
    input  logic               kill_id,
    input  logic               flush,
    input  logic               stall_ext,
    output logic               hazard_stall,
    output logic               illegal_op,
    output logic               reg_write_ex,
    output logic               mem_to_reg_ex,
    output logic               mem_read_ex,
    output logic               mem_write_ex,
    output logic               alu_src_ex,
    output logic               branch_ex,
    output logic               branch_ne_ex,
    output logic               jump_ex,
    output logic               link_ex,
    output logic [1:0]         reg_dst_ex,
    output logic [ALUOP_W-1:0] alu_op_ex,
    output logic [4:0]         dest_ex
);

    logic [5:0] opcode;
    logic [4:0] rs_id, rt_id, rd_id;
    logic       unused_instr_bits;

    assign opcode            = instr_id[31:26];
    assign rs_id             = instr_id[25:21];
    assign rt_id             = instr_id[20:16];
    assign rd_id             = instr_id[15:11];
    assign unused_instr_bits = ^instr_id[10:0];

    ctrl_t      dec_ctrl;
    logic [4:0] dec_dest;
    logic       dec_illegal;
    ctrl_t      ctrl_q;
    logic [4:0] dest_q;
    logic       illegal_q;
    logic       hazard_bubble;

    // Decode the opcode; the team NOP is a silent bubble, unknown ops are flagged.
    always_comb begin
        dec_ctrl    = decode(opcode);
        dec_illegal = !is_known(opcode) && (opcode != NOP_OP);
        if (opcode == NOP_OP) begin
            dec_ctrl = CTRL_BUBBLE;
        end
        case (dec_ctrl.reg_dst)
            DST_RT:  dec_dest = rt_id;
            DST_RD:  dec_dest = rd_id;
            DST_RA:  dec_dest = REG_RA;
            default: dec_dest = 5'd0;
        endcase
        if (!dec_ctrl.reg_write) begin
            dec_dest = 5'd0;
        end
    end

    id_hazard_fsm #(
        .LU_STALLS (LU_STALLS)
    ) u_hazard (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_read_ex   (ctrl_q.mem_read),
        .dest_ex       (dest_q),
        .valid_id      (valid_id),
        .kill_id       (kill_id),
        .rs_id         (rs_id),
        .rt_id         (rt_id),
        .uses_rt_id    (uses_rt(opcode)),
        .flush         (flush),
        .stall_ext     (stall_ext),
        .hazard_bubble (hazard_bubble),
        .hazard_stall  (hazard_stall)
    );

    // ID/EX register with flush > external stall > hazard > kill/invalid > decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= CTRL_BUBBLE;
            dest_q    <= 5'd0;
            illegal_q <= 1'b0;
        end else if (flush) begin
            ctrl_q    <= CTRL_BUBBLE;
            dest_q    <= 5'd0;
            illegal_q <= 1'b0;
        end else if (stall_ext) begin
            illegal_q <= 1'b0;
        end else if (hazard_bubble || !valid_id || kill_id) begin
            ctrl_q    <= CTRL_BUBBLE;
            dest_q    <= 5'd0;
            illegal_q <= 1'b0;
        end else begin
            ctrl_q    <= dec_ctrl;
            dest_q    <= dec_dest;
            illegal_q <= dec_illegal;
        end
    end

    assign reg_write_ex  = ctrl_q.reg_write;
    assign mem_to_reg_ex = ctrl_q.mem_to_reg;
    assign mem_read_ex   = ctrl_q.mem_read;
    assign mem_write_ex  = ctrl_q.mem_write;
    assign alu_src_ex    = ctrl_q.alu_src;
    assign branch_ex     = ctrl_q.branch;
    assign branch_ne_ex  = ctrl_q.branch_ne;
    assign jump_ex       = ctrl_q.jump;
    assign link_ex       = ctrl_q.link;
    assign reg_dst_ex    = ctrl_q.reg_dst;
    assign alu_op_ex     = ALUOP_W'(ctrl_q.alu_op);
    assign dest_ex       = dest_q;
    assign illegal_op    = illegal_q;

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Bench for id_ctrl_pipe: two instances (LU_STALLS=1 and 3) share stimulus and
// are compared each cycle against a behavioural model, plus directed vectors.
module tb_id_ctrl_pipe;

    localparam logic [5:0] NOP = 6'b100000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_id;
    logic        valid_id, kill_id, flush, stall_ext;

    always #5 clk = ~clk;

    logic       hs_1, ill_1, rw_1, m2r_1, mr_1, mw_1, as_1, br_1, bne_1, j_1, lnk_1;
    logic [1:0] dst_1;
    logic [2:0] alu_1;
    logic [4:0] dest_1;
    logic       hs_3, ill_3, rw_3, m2r_3, mr_3, mw_3, as_3, br_3, bne_3, j_3, lnk_3;
    logic [1:0] dst_3;
    logic [2:0] alu_3;
    logic [4:0] dest_3;

    id_ctrl_pipe #(.ALUOP_W(3), .LU_STALLS(1), .NOP_OP(NOP)) dut1 (
        .clk(clk), .rst_n(rst_n), .instr_id(instr_id), .valid_id(valid_id),
        .kill_id(kill_id), .flush(flush), .stall_ext(stall_ext),
        .hazard_stall(hs_1), .illegal_op(ill_1), .reg_write_ex(rw_1),
        .mem_to_reg_ex(m2r_1), .mem_read_ex(mr_1), .mem_write_ex(mw_1),
        .alu_src_ex(as_1), .branch_ex(br_1), .branch_ne_ex(bne_1), .jump_ex(j_1),
        .link_ex(lnk_1), .reg_dst_ex(dst_1), .alu_op_ex(alu_1), .dest_ex(dest_1));

    id_ctrl_pipe #(.ALUOP_W(3), .LU_STALLS(3), .NOP_OP(NOP)) dut3 (
        .clk(clk), .rst_n(rst_n), .instr_id(instr_id), .valid_id(valid_id),
        .kill_id(kill_id), .flush(flush), .stall_ext(stall_ext),
        .hazard_stall(hs_3), .illegal_op(ill_3), .reg_write_ex(rw_3),
        .mem_to_reg_ex(m2r_3), .mem_read_ex(mr_3), .mem_write_ex(mw_3),
        .alu_src_ex(as_3), .branch_ex(br_3), .branch_ne_ex(bne_3), .jump_ex(j_3),
        .link_ex(lnk_3), .reg_dst_ex(dst_3), .alu_op_ex(alu_3), .dest_ex(dest_3));

    logic [19:0] out1, out3;
    assign out1 = {rw_1, m2r_1, mr_1, mw_1, as_1, br_1, bne_1, j_1, lnk_1, dst_1, alu_1, dest_1, ill_1};
    assign out3 = {rw_3, m2r_3, mr_3, mw_3, as_3, br_3, bne_3, j_3, lnk_3, dst_3, alu_3, dest_3, ill_3};

    // Reference view of the ID/EX register, same bit order as out1/out3.
    typedef struct packed {
        logic       rw, m2r, mr, mw, asrc, br, bne, jmp, lnk;
        logic [1:0] dst;
        logic [2:0] alu;
        logic [4:0] dest;
        logic       ill;
    } ex_t;

    ex_t m_ex   [2];
    int  m_left [2];
    int  m_stalls [2];

    int  n_checks = 0;
    int  n_fail   = 0;
    logic hs1_seen, hs3_seen;

    function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
        return {6'b000000, rs, rt, rd, 5'd0, 6'b100000};
    endfunction

    // Decode straight from the opcode table: fields rw..lnk, dst, aluop.
    function automatic ex_t ref_decode(logic [31:0] ins);
        ex_t e;
        logic [5:0] op;
        e  = '0;
        op = ins[31:26];
        case (op)
            6'b000000: {e.rw, e.m2r, e.mr, e.mw, e.asrc, e.br, e.bne, e.jmp, e.lnk, e.dst, e.alu} = {9'b100000000, 2'd1, 3'd2};
            6'b001000: {e.rw, e.m2r, e.mr, e.mw, e.asrc, e.br, e.bne, e.jmp, e.lnk, e.dst, e.alu} = {9'b100010000, 2'd0, 3'd0};
            6'b001010: {e.rw, e.m2r, e.mr, e.mw, e.asrc, e.br, e.bne, e.jmp, e.lnk, e.dst, e.alu} = {9'b100010000, 2'd0, 3'd4};
            6'b001101: {e.rw, e.m2r, e.mr, e.mw, e.asrc, e.br, e.bne, e.jmp, e.lnk, e.dst, e.alu} = {9'b100010000, 2'd0, 3'd3};
            6'b100011: {e.rw, e.m2r, e.mr, e.mw, e.asrc, e.br, e.bne, e.jmp, e.lnk, e.dst, e.alu} = {9'b111010000, 2'd0, 3'd0};
            6'b101011: {e.rw, e.m2r, e.mr, e.mw, e.asrc, e.br, e.bne, e.jmp, e.lnk, e.dst, e.alu} = {9'b000110000, 2'd0, 3'd0};
            6'b000100: {e.rw, e.m2r, e.mr, e.mw, e.asrc, e.br, e.bne, e.jmp, e.lnk, e.dst, e.alu} = {9'b000001000, 2'd0, 3'd1};
            6'b000101: {e.rw, e.m2r, e.mr, e.mw, e.asrc, e.br, e.bne, e.jmp, e.lnk, e.dst, e.alu} = {9'b000000100, 2'd0, 3'd1};
            6'b000010: {e.rw, e.m2r, e.mr, e.mw, e.asrc, e.br, e.bne, e.jmp, e.lnk, e.dst, e.alu} = {9'b000000010, 2'd0, 3'd0};
            6'b000011: {e.rw, e.m2r, e.mr, e.mw, e.asrc, e.br, e.bne, e.jmp, e.lnk, e.dst, e.alu} = {9'b100000011, 2'd2, 3'd0};
            default:   e.ill = (op != NOP);
        endcase
        if (e.rw) begin
            if (e.dst == 2'd0)      e.dest = ins[20:16];
            else if (e.dst == 2'd1) e.dest = ins[15:11];
            else                    e.dest = 5'd31;
        end
        return e;
    endfunction

    function automatic logic ref_reads_rt(logic [5:0] op);
        return (op == 6'b000000) || (op == 6'b101011) || (op == 6'b000100) || (op == 6'b000101);
    endfunction

    // A load in EX writing a register that the live ID instruction reads.
    function automatic logic ref_detect(int k);
        logic [4:0] d;
        d = m_ex[k].dest;
        return (m_stalls[k] > 0) && m_ex[k].mr && (d != 5'd0) && valid_id && !kill_id &&
               ((d == instr_id[25:21]) || ((d == instr_id[20:16]) && ref_reads_rt(instr_id[31:26])));
    endfunction

    function automatic logic ref_stall(int k);
        return !flush && ((m_left[k] > 0) || ref_detect(k));
    endfunction

    // Advance the model by one clock edge.
    task automatic ref_step(int k);
        logic det;
        det = ref_detect(k);
        if (flush) begin
            m_ex[k]   = '0;
            m_left[k] = 0;
        end else if (stall_ext) begin
            m_ex[k].ill = 1'b0;
        end else if (m_left[k] > 0) begin
            m_ex[k]   = '0;
            m_left[k] = m_left[k] - 1;
        end else if (det) begin
            m_ex[k]   = '0;
            m_left[k] = m_stalls[k] - 1;
        end else if (!valid_id || kill_id) begin
            m_ex[k] = '0;
        end else begin
            m_ex[k] = ref_decode(instr_id);
        end
    endtask

    task automatic checkOutput(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive one cycle from a negedge: check hazard_stall, clock, check ID/EX.
    task automatic applyStimulus(logic [31:0] ins, logic v, logic k, logic f, logic s);
        instr_id  = ins;
        valid_id  = v;
        kill_id   = k;
        flush     = f;
        stall_ext = s;
        #1;
        hs1_seen = hs_1;
        hs3_seen = hs_3;
        checkOutput("hazard_stall_lu1", {31'd0, hs_1}, {31'd0, ref_stall(0)});
        checkOutput("hazard_stall_lu3", {31'd0, hs_3}, {31'd0, ref_stall(1)});
        @(posedge clk);
        ref_step(0);
        ref_step(1);
        #1;
        checkOutput("ex_bundle_lu1", {12'd0, out1}, {12'd0, m_ex[0]});
        checkOutput("ex_bundle_lu3", {12'd0, out3}, {12'd0, m_ex[1]});
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] ins;
        logic        v, k;
        logic        hs1, hs3;
        logic        rw1;
        logic [4:0]  dest1;
        logic        ill1;
    } vec_t;

    vec_t tbl [15];

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt1, cnt3;
        logic [5:0] ops [12];
        m_stalls[0] = 1;
        m_stalls[1] = 3;
        ops = '{6'b000000, 6'b001000, 6'b001010, 6'b001101, 6'b100011, 6'b101011,
                6'b000100, 6'b000101, 6'b000010, 6'b000011, 6'b100000, 6'b111111};

        // Reset: everything low, hazard_stall low.
        rst_n = 1'b0; instr_id = '0; valid_id = 0; kill_id = 0; flush = 0; stall_ext = 0;
        for (int k = 0; k < 2; k++) begin m_ex[k] = '0; m_left[k] = 0; end
        #3;
        checkOutput("reset_out_lu1", {12'd0, out1}, 32'd0);
        checkOutput("reset_out_lu3", {12'd0, out3}, 32'd0);
        checkOutput("reset_hs", {30'd0, hs_1, hs_3}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ins, valid, kill, hs1, hs3 (before edge), rw1, dest1, ill1 (after edge)
        tbl[0]  = '{rtype(5'd8, 5'd2, 5'd9),                1, 0, 0, 0, 1, 5'd9,  0};
        tbl[1]  = '{{6'b000011, 26'h0000123},               1, 0, 0, 0, 1, 5'd31, 0};
        tbl[2]  = '{itype(6'b000101, 5'd4, 5'd5, 16'h0010), 1, 0, 0, 0, 0, 5'd0,  0};
        tbl[3]  = '{itype(6'b001101, 5'd6, 5'd7, 16'h00ff), 1, 0, 0, 0, 1, 5'd7,  0};
        tbl[4]  = '{{6'b111111, 26'h0},                     1, 0, 0, 0, 0, 5'd0,  1};
        tbl[5]  = '{{6'b111111, 26'h0},                     1, 1, 0, 0, 0, 5'd0,  0};
        tbl[6]  = '{{NOP, 26'h0421800},                     1, 0, 0, 0, 0, 5'd0,  0};
        tbl[7]  = '{itype(6'b001000, 5'd1, 5'd0, 16'h0005), 1, 0, 0, 0, 1, 5'd0,  0};
        tbl[8]  = '{itype(6'b100011, 5'd1, 5'd8, 16'h0000), 1, 0, 0, 0, 1, 5'd8,  0};
        tbl[9]  = '{itype(6'b101011, 5'd3, 5'd8, 16'h0004), 1, 0, 1, 1, 0, 5'd0,  0};
        tbl[10] = '{itype(6'b101011, 5'd3, 5'd8, 16'h0004), 1, 0, 0, 1, 0, 5'd0,  0};
        tbl[11] = '{itype(6'b101011, 5'd3, 5'd8, 16'h0004), 1, 0, 0, 1, 0, 5'd0,  0};
        tbl[12] = '{itype(6'b100011, 5'd1, 5'd0, 16'h0000), 1, 0, 0, 0, 1, 5'd0,  0};
        tbl[13] = '{rtype(5'd0, 5'd0, 5'd9),                1, 0, 0, 0, 1, 5'd9,  0};
        tbl[14] = '{{6'b111111, 26'h0},                     0, 0, 0, 0, 0, 5'd0,  0};

        for (int i = 0; i < 15; i++) begin
            applyStimulus(tbl[i].ins, tbl[i].v, tbl[i].k, 1'b0, 1'b0);
            checkOutput($sformatf("tbl%0d_hs1", i), {31'd0, hs1_seen}, {31'd0, tbl[i].hs1});
            checkOutput($sformatf("tbl%0d_hs3", i), {31'd0, hs3_seen}, {31'd0, tbl[i].hs3});
            checkOutput($sformatf("tbl%0d_rw", i), {31'd0, rw_1}, {31'd0, tbl[i].rw1});
            checkOutput($sformatf("tbl%0d_dest", i), {27'd0, dest_1}, {27'd0, tbl[i].dest1});
            checkOutput($sformatf("tbl%0d_ill", i), {31'd0, ill_1}, {31'd0, tbl[i].ill1});
        end

        // LW $8 then ADD $9,$8,$2 with a 2-cycle external stall in the middle.
        applyStimulus(itype(6'b100011, 5'd1, 5'd8, 16'h0), 1, 0, 0, 0);
        cnt1 = 0;
        cnt3 = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(rtype(5'd8, 5'd2, 5'd9), 1, 0, 0, (i == 1) || (i == 2));
            cnt1 += int'(hs1_seen);
            cnt3 += int'(hs3_seen);
            if (i == 0) checkOutput("lu1_bubble_dest", {27'd0, dest_1}, 32'd0);
            if (i == 3) checkOutput("lu1_add_dest", {27'd0, dest_1}, 32'd9);
            if (i == 4) checkOutput("lu3_last_bubble", {27'd0, dest_3}, 32'd0);
        end
        checkOutput("lu1_hs_cycles", cnt1, 32'd1);
        checkOutput("lu3_hs_cycles", cnt3, 32'd5);
        checkOutput("lu3_add_dest", {27'd0, dest_3}, 32'd9);

        // Flush while LU_WAIT: stall drops in the same cycle, FSM back to RUN.
        applyStimulus(itype(6'b100011, 5'd1, 5'd8, 16'h0), 1, 0, 0, 0);
        applyStimulus(rtype(5'd8, 5'd2, 5'd9), 1, 0, 0, 0);
        applyStimulus(rtype(5'd8, 5'd2, 5'd9), 1, 0, 1, 0);
        checkOutput("flush_hs3", {31'd0, hs3_seen}, 32'd0);
        checkOutput("flush_bubble", {12'd0, out3}, 32'd0);
        applyStimulus(rtype(5'd8, 5'd2, 5'd9), 1, 0, 0, 0);
        checkOutput("after_flush_hs3", {31'd0, hs3_seen}, 32'd0);
        checkOutput("after_flush_dest", {27'd0, dest_3}, 32'd9);

        // Asynchronous reset in the middle of LU_WAIT.
        applyStimulus(itype(6'b100011, 5'd1, 5'd8, 16'h0), 1, 0, 0, 0);
        applyStimulus(rtype(5'd8, 5'd2, 5'd9), 1, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_lu1", {12'd0, out1}, 32'd0);
        checkOutput("async_rst_lu3", {12'd0, out3}, 32'd0);
        checkOutput("async_rst_hs", {30'd0, hs_1, hs_3}, 32'd0);
        for (int k = 0; k < 2; k++) begin m_ex[k] = '0; m_left[k] = 0; end
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(rtype(5'd11, 5'd12, 5'd10), 1, 0, 0, 0);
        checkOutput("post_rst_dest", {27'd0, dest_3}, 32'd10);
        checkOutput("post_rst_rw", {31'd0, rw_3}, 32'd1);

        // Random traffic against the model, small register range to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            logic [5:0] op;
            logic [31:0] ins;
            op  = ($urandom_range(0, 3) == 0) ? 6'b100011 : ops[$urandom_range(0, 11)];
            ins = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 11'($urandom)};
            applyStimulus(ins, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
